// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined slave over a word-addressed on-chip memory.
// Requests are queued in order and answered one per pop after an optional delay.
module wb_mem_slave #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned MEM_AWIDTH   = 10,
    parameter int unsigned QUEUE_AWIDTH = 2,
    parameter int unsigned ACK_DELAY    = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [AWIDTH-1:0] wb_adr_i,
    input  logic [DWIDTH-1:0] wb_dat_i,
    input  logic [DWIDTH/8-1:0] wb_sel_i,
    output logic              wb_stall_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [DWIDTH-1:0] wb_dat_o
);
    localparam int DEPTH     = 1 << QUEUE_AWIDTH;
    localparam int MEM_DEPTH = 1 << MEM_AWIDTH;
    localparam int SWIDTH    = DWIDTH / 8;

    logic [DWIDTH-1:0]     r_mem [MEM_DEPTH];

    logic                  r_q_we  [DEPTH];
    logic                  r_q_bad [DEPTH];
    logic [MEM_AWIDTH-1:0] r_q_idx [DEPTH];
    logic [SWIDTH-1:0]     r_q_sel [DEPTH];
    logic [DWIDTH-1:0]     r_q_dat [DEPTH];

    logic [QUEUE_AWIDTH-1:0] r_wr_ptr;
    logic [QUEUE_AWIDTH-1:0] r_rd_ptr;
    logic [QUEUE_AWIDTH:0]   r_count;
    logic [3:0]              r_dly;
    logic                    r_ack;
    logic                    r_err;
    logic [DWIDTH-1:0]       r_dat;

    logic                    w_bad;
    logic [MEM_AWIDTH-1:0]   w_idx;
    logic                    w_stall;
    logic                    w_push;
    logic                    w_pop;
    logic [QUEUE_AWIDTH:0]   w_count_nxt;
    logic                    w_load;
    logic                    w_head_we;
    logic                    w_head_bad;
    logic [MEM_AWIDTH-1:0]   w_head_idx;
    logic [SWIDTH-1:0]       w_head_sel;
    logic [DWIDTH-1:0]       w_head_dat;
    logic                    w_mem_we;

    always_comb begin
        w_bad       = (wb_adr_i[1:0] != 2'b00) | (wb_adr_i[AWIDTH-1:MEM_AWIDTH+2] != '0);
        w_idx       = wb_adr_i[MEM_AWIDTH+1:2];
        // Stall looks only at the registered count: a full queue stalls even while popping.
        w_stall     = (r_count == (QUEUE_AWIDTH+1)'(DEPTH));
        w_push      = wb_cyc_i & wb_stb_i & ~w_stall;
        w_pop       = wb_cyc_i & (r_count != '0) & (r_dly == 4'd0);
        w_count_nxt = r_count + (QUEUE_AWIDTH+1)'(w_push) - (QUEUE_AWIDTH+1)'(w_pop);
        // A new head restarts the response delay.
        w_load      = (w_push & (r_count == '0)) | (w_pop & (w_count_nxt != '0));
        w_head_we   = r_q_we[r_rd_ptr];
        w_head_bad  = r_q_bad[r_rd_ptr];
        w_head_idx  = r_q_idx[r_rd_ptr];
        w_head_sel  = r_q_sel[r_rd_ptr];
        w_head_dat  = r_q_dat[r_rd_ptr];
        w_mem_we    = wb_rst_n_i & w_pop & w_head_we & ~w_head_bad;
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_q_we[r_wr_ptr]  <= wb_we_i;
            r_q_bad[r_wr_ptr] <= w_bad;
            r_q_idx[r_wr_ptr] <= w_idx;
            r_q_sel[r_wr_ptr] <= wb_sel_i;
            r_q_dat[r_wr_ptr] <= wb_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_mem_we) begin
            for (int k = 0; k < SWIDTH; k++) begin
                if (w_head_sel[k]) begin
                    r_mem[w_head_idx][8*k +: 8] <= w_head_dat[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dly    <= 4'd0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
        end else if (!wb_cyc_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dly    <= 4'd0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            if (w_load) begin
                r_dly <= 4'(ACK_DELAY);
            end else if (r_dly != 4'd0) begin
                r_dly <= r_dly - 4'd1;
            end
            r_ack <= w_pop & ~w_head_bad;
            r_err <= w_pop & w_head_bad;
            if (w_pop & ~w_head_we & ~w_head_bad) begin
                r_dat <= r_mem[w_head_idx];
            end
        end
    end

    assign wb_stall_o = w_stall;
    assign wb_ack_o   = r_ack & wb_cyc_i;
    assign wb_err_o   = r_err & wb_cyc_i;
    assign wb_dat_o   = r_dat;
endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: directed scenarios plus random traffic, all checked every
// cycle against a queue/array model of the slave.
module tb_wb_mem_slave;
    localparam int DLY   = 2;
    localparam int QAW   = 2;
    localparam int DEPTH = 1 << QAW;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] adr   = '0;
    logic [31:0] wdat  = '0;
    logic [3:0]  sel   = '0;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] rdat;

    always #5 clk = ~clk;

    wb_mem_slave #(
        .DWIDTH      (32),
        .AWIDTH      (32),
        .MEM_AWIDTH  (10),
        .QUEUE_AWIDTH(QAW),
        .ACK_DELAY   (DLY)
    ) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (wdat),
        .wb_sel_i  (sel),
        .wb_stall_o(stall),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .wb_dat_o  (rdat)
    );

    typedef struct packed {
        logic        we;
        logic        bad;
        logic [9:0]  idx;
        logic [3:0]  sel;
        logic [31:0] dat;
    } req_t;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [31:0] dat;
    } rsp_t;

    req_t        mq[$];
    rsp_t        rlog[$];
    logic [31:0] mmem [1024];
    int          cyc_n      = 0;
    int          head_ready = 0;
    logic        m_ack_r    = 1'b0;
    logic        m_err_r    = 1'b0;
    logic [31:0] m_dat      = '0;
    bit          m_acc      = 1'b0;
    bit          chk_en     = 1'b0;
    int          n_chk      = 0;
    int          n_fail     = 0;
    int          n_stall    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: in-order queue; the head may issue DLY cycles after it became head.
    task automatic model_update();
        int   size0;
        bit   pop;
        bit   push;
        req_t r;
        rsp_t s;
        size0 = mq.size();
        m_acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            m_ack_r = 1'b0;
            m_err_r = 1'b0;
            m_dat   = '0;
        end else if (!cyc) begin
            mq.delete();
            m_ack_r = 1'b0;
            m_err_r = 1'b0;
        end else begin
            pop     = (size0 > 0) && (cyc_n >= head_ready);
            push    = stb && (size0 < DEPTH);
            m_ack_r = 1'b0;
            m_err_r = 1'b0;
            if (pop) begin
                r = mq.pop_front();
                if (r.bad) begin
                    m_err_r = 1'b1;
                end else begin
                    m_ack_r = 1'b1;
                    if (r.we) begin
                        for (int k = 0; k < 4; k++) begin
                            if (r.sel[k]) mmem[r.idx][8*k +: 8] = r.dat[8*k +: 8];
                        end
                    end else begin
                        m_dat = mmem[r.idx];
                    end
                end
                s.cyc    = cyc_n + 1;
                s.is_err = r.bad;
                s.dat    = m_dat;
                rlog.push_back(s);
            end
            if (push) begin
                r.we  = we;
                r.bad = (adr[1:0] != 2'b00) || (adr[31:12] != 20'd0);
                r.idx = adr[11:2];
                r.sel = sel;
                r.dat = wdat;
                mq.push_back(r);
                m_acc = 1'b1;
            end
            if ((pop && mq.size() > 0) || (push && size0 == 0)) head_ready = cyc_n + 1 + DLY;
        end
        cyc_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(mq.size() == DEPTH));
            chk("ack",   32'(ack),   32'(m_ack_r & cyc));
            chk("err",   32'(err),   32'(m_err_r & cyc));
            chk("rdata", rdat,       m_dat);
            if (stall) n_stall++;
        end
    end

    task automatic set_idle();
        cyc = 1'b1;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc_cyc);
        cyc = 1'b1;
        stb = 1'b1;
        we  = w;
        adr = a;
        wdat = d;
        sel = s;
        acc_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m_acc) begin
                acc_cyc = cyc_n - 1;
                break;
            end
        end
        chk("accept", 32'(m_acc), 32'd1);
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < 100 && mq.size() > 0; i++) tick();
        tick();
        tick();
        chk("drain", 32'(mq.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int n0;
        int s0;
        int idx;
        int k;

        rst_n = 1'b0;
        cyc   = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dat",   rdat,       32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 32; i++) req(1'b1, 32'(i * 4), $urandom, 4'hF, t0);
        drain();

        // Write then read
        n0 = rlog.size();
        req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, t0);
        drain();
        req(1'b0, 32'h10, 32'h0, 4'h0, t1);
        drain();
        chk("wr_rd_nrsp", 32'(rlog.size() - n0), 32'd2);
        chk("wr_lat",     32'(rlog[n0].cyc - t0), 32'(2 + DLY));
        chk("rd_lat",     32'(rlog[n0+1].cyc - t1), 32'(2 + DLY));
        chk("rd_data",    rlog[n0+1].dat, 32'hDEADBEEF);
        chk("rd_hold",    rdat, 32'hDEADBEEF);

        // Burst reads of preloaded 1..4
        for (int i = 0; i < 4; i++) req(1'b1, 32'(32'h40 + 4 * i), 32'(i + 1), 4'hF, t0);
        drain();
        n0 = rlog.size();
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 32'(32'h40 + 4 * i), 32'h0, 4'hF, t1);
            if (i == 0) t0 = t1;
        end
        drain();
        chk("burst_first_lat", 32'(rlog[n0].cyc - t0), 32'(2 + DLY));
        for (int i = 0; i < 4; i++) begin
            chk("burst_data", rlog[n0+i].dat, 32'(i + 1));
            if (i > 0) chk("burst_gap", 32'(rlog[n0+i].cyc - rlog[n0+i-1].cyc), 32'(DLY + 1));
        end

        // Byte enables
        n0 = rlog.size();
        req(1'b1, 32'h20, 32'h11223344, 4'hF, t0);
        req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0010, t0);
        req(0, 32'h20, 32'h0, 4'hF, t0);
        drain();
        chk("byte_en", rlog[n0+2].dat, 32'h1122CC44);

        // Error terminations leave memory untouched
        req(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, t0);
        drain();
        n0 = rlog.size();
        req(1'b0, 32'h1000, 32'h0, 4'hF, t0);
        req(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, t0);
        req(1'b0, 32'h0, 32'h0, 4'hF, t0);
        drain();
        chk("err_rd",    32'(rlog[n0].is_err), 32'd1);
        chk("err_wr",    32'(rlog[n0+1].is_err), 32'd1);
        chk("err_after", rlog[n0+2].dat, 32'h5A5A5A5A);

        // Stall: 6 back-to-back reads into a 4-deep queue
        n0 = rlog.size();
        s0 = n_stall;
        for (int i = 0; i < 6; i++) req(1'b0, 32'(32'h40 + 4 * (i % 4)), 32'h0, 4'hF, t0);
        drain();
        chk("stall_nrsp", 32'(rlog.size() - n0), 32'd6);
        chk("stall_seen", 32'(n_stall > s0), 32'd1);
        for (int i = 1; i < 6; i++)
            chk("stall_gap", 32'(rlog[n0+i].cyc - rlog[n0+i-1].cyc), 32'(DLY + 1));

        // Abort after first ack
        n0 = rlog.size();
        for (int i = 0; i < 4; i++) req(1'b0, 32'(32'h40 + 4 * i), 32'h0, 4'hF, t0);
        set_idle();
        for (int i = 0; i < 40 && rlog.size() == n0; i++) tick();
        tick();
        cyc = 1'b0;
        tick();
        idle(12);
        chk("abort_nrsp", 32'(rlog.size() - n0), 32'd1);
        chk("abort_q",    32'(mq.size()), 32'd0);

        // Reset mid-burst
        n0 = rlog.size();
        for (int i = 0; i < 4; i++) req(1'b0, 32'(32'h40 + 4 * i), 32'h0, 4'hF, t0);
        set_idle();
        for (int i = 0; i < 40 && rlog.size() == n0; i++) tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_ack",   32'(ack),   32'd0);
        chk("mrst_err",   32'(err),   32'd0);
        chk("mrst_stall", 32'(stall), 32'd0);
        chk("mrst_dat",   rdat,       32'd0);
        rst_n = 1'b1;
        idle(12);
        chk("mrst_nrsp", 32'(rlog.size() - n0), 32'd1);

        // Random traffic within the initialised window, with occasional bad/abort/reset
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cyc   = ($urandom_range(0, 24) != 0);
            stb   = ($urandom_range(0, 2) != 0);
            we    = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, 31);
            adr   = 32'(idx * 4);
            k     = $urandom_range(0, 19);
            if (k == 0) adr[1:0] = 2'($urandom_range(1, 3));
            if (k == 1) adr[12 + $urandom_range(0, 19)] = 1'b1;
            wdat  = $urandom;
            sel   = 4'($urandom);
            tick();
        end
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
